// File: rtl/elbeth_lsu_pkg.sv
// Shared encodings and helpers for the elbeth load/store unit.
// Byte-lane masks are computed at the widest supported width (8 lanes).
package elbeth_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // 2^size consecutive ones, shifted up to the byte offset within the word.
  function automatic logic [7:0] byte_mask(input size_e size, input logic [2:0] offset);
    logic [8:0] ones;
    ones = (9'd1 << (4'd1 << size)) - 9'd1;
    return ones[7:0] << offset;
  endfunction

endpackage

// File: rtl/elbeth_load_align.sv
// Combinational load extraction: shift the addressed bytes down, keep 2^size
// bytes and sign- or zero-extend the result to XLEN.
module elbeth_load_align
  import elbeth_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OW-1:0]   offset,
  input  size_e           size,
  input  logic            is_signed,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic            sign;
  int              nbits;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = data >> {offset, 3'b000};
    nbits   = 8 << int'(size);
    if (nbits > XLEN) nbits = XLEN;
    unique case (size)
      SIZE_B:  sign = shifted[7];
      SIZE_H:  sign = shifted[15];
      SIZE_W:  sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign   = sign & is_signed;
    result = '0;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/elbeth_lsu.sv
// Handshaked load/store unit between EXS and the data memory port: lane
// enables, store replication, alignment checks, load extension, exceptions.
module elbeth_lsu
  import elbeth_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  lsu_stall,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  exc_misaligned,
  output logic                  exc_bus_error,
  output logic                  exc_timeout,
  output logic [ADDR_WIDTH-1:0] exc_addr,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_en,
  output logic [XLEN/8-1:0]     dmem_rw,
  output logic [XLEN-1:0]       dmem_out_data,
  input  logic [XLEN-1:0]       dmem_in_data,
  input  logic                  dmem_ready,
  input  logic                  dmem_error
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e            state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [OW-1:0]         off_q;
  size_e                 size_q;
  logic                  signed_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  size_e                 req_sz;
  logic                  misaligned;
  logic [NB-1:0]         lane_mask;
  logic [XLEN-1:0]       wdata_rep;
  logic [XLEN-1:0]       load_data;
  logic                  timeout_hit;
  logic                  accept_ok, accept_bad;
  logic                  exit_err, exit_rdy, exit_to;

  assign req_sz      = size_e'(req_size);
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign lane_mask   = NB'(byte_mask(req_sz, 3'(req_addr[OW-1:0])));

  // A double access on a 32-bit datapath has no legal alignment at all.
  always_comb begin
    misaligned = ((req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1)) != 3'd0) ||
                 (req_sz == SIZE_D && XLEN < 64);
  end

  always_comb begin
    unique case (req_sz)
      SIZE_B:  wdata_rep = {NB{req_wdata[7:0]}};
      SIZE_H:  wdata_rep = {(NB / 2){req_wdata[15:0]}};
      SIZE_W:  wdata_rep = {(NB / 4){req_wdata[31:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  elbeth_load_align #(
    .XLEN (XLEN),
    .OW   (OW)
  ) u_load_align (
    .data      (dmem_in_data),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LSU_IDLE: if (req_valid) state_nxt = misaligned ? LSU_RESP : LSU_WAIT;
      LSU_WAIT: if (exit_err || exit_rdy || exit_to) state_nxt = LSU_RESP;
      LSU_RESP: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  // Event decode; WAIT exits are prioritised error > ready > timeout.
  always_comb begin
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    exit_err   = 1'b0;
    exit_rdy   = 1'b0;
    exit_to    = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        accept_bad = req_valid && misaligned;
        accept_ok  = req_valid && !misaligned;
      end
      LSU_WAIT: begin
        if (dmem_error)       exit_err = 1'b1;
        else if (dmem_ready)  exit_rdy = 1'b1;
        else if (timeout_hit) exit_to  = 1'b1;
      end
      default: ;
    endcase
  end

  assign lsu_stall = (state == LSU_WAIT) || (state == LSU_IDLE && req_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      exc_misaligned <= 1'b0;
      exc_bus_error  <= 1'b0;
      exc_timeout    <= 1'b0;
      exc_addr       <= '0;
      dmem_addr      <= '0;
      dmem_en        <= 1'b0;
      dmem_rw        <= '0;
      dmem_out_data  <= '0;
      cnt            <= '0;
      off_q          <= '0;
      size_q         <= SIZE_B;
      signed_q       <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
    end else begin
      resp_valid     <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_bus_error  <= 1'b0;
      exc_timeout    <= 1'b0;

      if (accept_bad) begin
        exc_misaligned <= 1'b1;
        exc_addr       <= req_addr;
      end

      if (accept_ok) begin
        dmem_addr     <= {req_addr[ADDR_WIDTH-1:OW], OW'(0)};
        dmem_en       <= 1'b1;
        dmem_rw       <= req_we ? lane_mask : '0;
        dmem_out_data <= req_we ? wdata_rep : '0;
        off_q         <= req_addr[OW-1:0];
        size_q        <= req_sz;
        signed_q      <= req_signed;
        we_q          <= req_we;
        addr_q        <= req_addr;
        cnt           <= '0;
      end

      if (state == LSU_WAIT) begin
        cnt <= cnt + CW'(1);
        if (exit_err || exit_rdy || exit_to) begin
          dmem_en <= 1'b0;
          dmem_rw <= '0;
        end
        if (exit_err) begin
          exc_bus_error <= 1'b1;
          exc_addr      <= addr_q;
        end
        if (exit_rdy) begin
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? '0 : load_data;
        end
        if (exit_to) begin
          exc_timeout <= 1'b1;
          exc_addr    <= addr_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_elbeth_lsu.sv
// Directed bench for elbeth_lsu: a 32-bit instance (short timeout) and a
// 64-bit instance, a vector table plus hand-written multi-cycle sequences.
module tb_elbeth_lsu;
  import elbeth_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_req_valid, a_req_we, a_req_signed;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_lsu_stall, a_resp_valid, a_exc_mis, a_exc_bus, a_exc_to;
  logic [31:0] a_resp_rdata, a_exc_addr, a_dmem_addr, a_dmem_out, a_dmem_in;
  logic        a_dmem_en, a_dmem_ready, a_dmem_error;
  logic [3:0]  a_dmem_rw;

  // 64-bit instance
  logic        b_req_valid, b_req_we, b_req_signed;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_lsu_stall, b_resp_valid, b_exc_mis, b_exc_bus, b_exc_to;
  logic [63:0] b_resp_rdata, b_dmem_out, b_dmem_in;
  logic [31:0] b_exc_addr, b_dmem_addr;
  logic        b_dmem_en, b_dmem_ready, b_dmem_error;
  logic [7:0]  b_dmem_rw;

  elbeth_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_we(a_req_we), .req_size(a_req_size),
    .req_signed(a_req_signed), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .lsu_stall(a_lsu_stall), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .exc_misaligned(a_exc_mis), .exc_bus_error(a_exc_bus), .exc_timeout(a_exc_to),
    .exc_addr(a_exc_addr), .dmem_addr(a_dmem_addr), .dmem_en(a_dmem_en),
    .dmem_rw(a_dmem_rw), .dmem_out_data(a_dmem_out), .dmem_in_data(a_dmem_in),
    .dmem_ready(a_dmem_ready), .dmem_error(a_dmem_error)
  );

  elbeth_lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_we(b_req_we), .req_size(b_req_size),
    .req_signed(b_req_signed), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .lsu_stall(b_lsu_stall), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .exc_misaligned(b_exc_mis), .exc_bus_error(b_exc_bus), .exc_timeout(b_exc_to),
    .exc_addr(b_exc_addr), .dmem_addr(b_dmem_addr), .dmem_en(b_dmem_en),
    .dmem_rw(b_dmem_rw), .dmem_out_data(b_dmem_out), .dmem_in_data(b_dmem_in),
    .dmem_ready(b_dmem_ready), .dmem_error(b_dmem_error)
  );

  // Output view of whichever instance the current vector targets.
  logic        sel64;
  logic        m_stall, m_resp, m_mis, m_bus, m_to, m_en;
  logic [63:0] m_rdata, m_odata;
  logic [31:0] m_exc_addr, m_daddr;
  logic [7:0]  m_rw;
  always_comb begin
    m_stall    = sel64 ? b_lsu_stall  : a_lsu_stall;
    m_resp     = sel64 ? b_resp_valid : a_resp_valid;
    m_mis      = sel64 ? b_exc_mis    : a_exc_mis;
    m_bus      = sel64 ? b_exc_bus    : a_exc_bus;
    m_to       = sel64 ? b_exc_to     : a_exc_to;
    m_en       = sel64 ? b_dmem_en    : a_dmem_en;
    m_rdata    = sel64 ? b_resp_rdata : {32'h0, a_resp_rdata};
    m_odata    = sel64 ? b_dmem_out   : {32'h0, a_dmem_out};
    m_exc_addr = sel64 ? b_exc_addr   : a_exc_addr;
    m_daddr    = sel64 ? b_dmem_addr  : a_dmem_addr;
    m_rw       = sel64 ? b_dmem_rw    : {4'h0, a_dmem_rw};
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        w64;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem;
    logic        mis;
    logic [7:0]  rw;
    logic [63:0] odata;
    logic [31:0] daddr;
    logic [63:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic w64, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [63:0] mem,
                              input logic mis, input logic [7:0] rw,
                              input logic [63:0] odata, input logic [31:0] daddr,
                              input logic [63:0] rdata);
    vec_t v;
    v.w64 = w64; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.mem = mem; v.mis = mis; v.rw = rw; v.odata = odata;
    v.daddr = daddr; v.rdata = rdata;
    return v;
  endfunction

  task automatic idle_inputs();
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_signed = 0;
    a_req_addr = 0; a_req_wdata = 0; a_dmem_in = 0; a_dmem_ready = 0; a_dmem_error = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_signed = 0;
    b_req_addr = 0; b_req_wdata = 0; b_dmem_in = 0; b_dmem_ready = 0; b_dmem_error = 0;
  endtask

  task automatic drive_req(input vec_t v, input logic valid);
    if (v.w64) begin
      b_req_valid = valid; b_req_we = v.we; b_req_size = v.size;
      b_req_signed = v.sgn; b_req_addr = v.addr; b_req_wdata = v.wdata;
    end else begin
      a_req_valid = valid; a_req_we = v.we; a_req_size = v.size;
      a_req_signed = v.sgn; a_req_addr = v.addr; a_req_wdata = v.wdata[31:0];
    end
  endtask

  task automatic drive_mem(input logic w64, input logic rdy, input logic [63:0] data);
    if (w64) begin b_dmem_ready = rdy; b_dmem_in = data; end
    else     begin a_dmem_ready = rdy; a_dmem_in = data[31:0]; end
  endtask

  // One request; memory answers in the first WAIT cycle.
  task automatic run_vec(input vec_t v, input int idx);
    sel64 = v.w64;
    @(posedge clk); #1;
    drive_req(v, 1'b1);
    #1;
    check($sformatf("v%0d.stall_req", idx), m_stall, 1);
    @(posedge clk); #1;
    drive_req(v, 1'b0);
    #1;
    if (v.mis) begin
      check($sformatf("v%0d.exc_mis", idx), m_mis, 1);
      check($sformatf("v%0d.exc_addr", idx), m_exc_addr, v.addr);
      check($sformatf("v%0d.en_mis", idx), m_en, 0);
      check($sformatf("v%0d.stall_resp", idx), m_stall, 0);
      @(posedge clk); #2;
      check($sformatf("v%0d.exc_mis_clr", idx), m_mis, 0);
      check($sformatf("v%0d.en_after", idx), m_en, 0);
    end else begin
      check($sformatf("v%0d.en", idx), m_en, 1);
      check($sformatf("v%0d.daddr", idx), m_daddr, v.daddr);
      check($sformatf("v%0d.rw", idx), m_rw, v.rw);
      if (v.we) check($sformatf("v%0d.odata", idx), m_odata, v.odata);
      check($sformatf("v%0d.stall_wait", idx), m_stall, 1);
      drive_mem(v.w64, 1'b1, v.mem);
      @(posedge clk); #1;
      drive_mem(v.w64, 1'b0, 64'h0);
      #1;
      check($sformatf("v%0d.resp", idx), m_resp, 1);
      check($sformatf("v%0d.rdata", idx), m_rdata, v.rdata);
      check($sformatf("v%0d.exc_none", idx), {m_mis, m_bus, m_to}, 0);
      check($sformatf("v%0d.en_drop", idx), {m_en, m_rw}, 0);
      check($sformatf("v%0d.stall_resp", idx), m_stall, 0);
      @(posedge clk); #2;
      check($sformatf("v%0d.resp_clr", idx), m_resp, 0);
      check($sformatf("v%0d.rdata_hold", idx), m_rdata, v.rdata);
    end
  endtask

  // Accept a 32-bit load; returns during the first WAIT cycle.
  task automatic start_a(input logic [31:0] addr, input logic [1:0] size);
    sel64 = 0;
    @(posedge clk); #1;
    a_req_valid = 1; a_req_we = 0; a_req_size = size; a_req_signed = 0; a_req_addr = addr;
    @(posedge clk); #1;
    a_req_valid = 0;
    #1;
  endtask

  vec_t vecs [16];
  int   nvec;

  initial begin
    bit seen;
    int en_cnt;

    idle_inputs();
    sel64 = 0;
    nvec  = 0;
    //                 w64 we size sgn  addr          wdata                  mem                    mis rw     odata                  daddr         rdata
    vecs[nvec++] = mk(0, 0, 2'd0, 1, 32'h103, 64'h0,                 64'h80FF_1234,         0, 8'h00, 64'h0,                 32'h100, 64'hFFFF_FF80);
    vecs[nvec++] = mk(0, 1, 2'd1, 0, 32'h202, 64'h0000_ABCD,         64'h0,                 0, 8'h0C, 64'hABCD_ABCD,         32'h200, 64'h0);
    vecs[nvec++] = mk(0, 0, 2'd2, 0, 32'h001, 64'h0,                 64'h0,                 1, 8'h00, 64'h0,                 32'h0,   64'h0);
    vecs[nvec++] = mk(0, 0, 2'd1, 0, 32'h102, 64'h0,                 64'h80FF_1234,         0, 8'h00, 64'h0,                 32'h100, 64'h0000_80FF);
    vecs[nvec++] = mk(0, 0, 2'd1, 1, 32'h102, 64'h0,                 64'h80FF_1234,         0, 8'h00, 64'h0,                 32'h100, 64'hFFFF_80FF);
    vecs[nvec++] = mk(0, 1, 2'd0, 0, 32'h301, 64'h1234_5678,         64'h0,                 0, 8'h02, 64'h7878_7878,         32'h300, 64'h0);
    vecs[nvec++] = mk(0, 1, 2'd2, 0, 32'h400, 64'hDEAD_BEEF,         64'h0,                 0, 8'h0F, 64'hDEAD_BEEF,         32'h400, 64'h0);
    vecs[nvec++] = mk(0, 0, 2'd0, 0, 32'h100, 64'h0,                 64'h80FF_1234,         0, 8'h00, 64'h0,                 32'h100, 64'h0000_0034);
    vecs[nvec++] = mk(0, 0, 2'd3, 0, 32'h008, 64'h0,                 64'h0,                 1, 8'h00, 64'h0,                 32'h0,   64'h0);
    vecs[nvec++] = mk(0, 0, 2'd2, 1, 32'h104, 64'h0,                 64'h8765_4321,         0, 8'h00, 64'h0,                 32'h104, 64'h8765_4321);
    vecs[nvec++] = mk(0, 1, 2'd1, 0, 32'h203, 64'h0000_1111,         64'h0,                 1, 8'h00, 64'h0,                 32'h0,   64'h0);
    vecs[nvec++] = mk(1, 0, 2'd3, 0, 32'h008, 64'h0,                 64'hDEAD_BEEF_0123_4567, 0, 8'h00, 64'h0,               32'h008, 64'hDEAD_BEEF_0123_4567);
    vecs[nvec++] = mk(1, 1, 2'd0, 0, 32'h005, 64'h78,                64'h0,                 0, 8'h20, 64'h7878_7878_7878_7878, 32'h000, 64'h0);
    vecs[nvec++] = mk(1, 0, 2'd2, 1, 32'h00C, 64'h0,                 64'h8000_0001_0000_0000, 0, 8'h00, 64'h0,               32'h008, 64'hFFFF_FFFF_8000_0001);
    vecs[nvec++] = mk(1, 0, 2'd3, 0, 32'h004, 64'h0,                 64'h0,                 1, 8'h00, 64'h0,                 32'h0,   64'h0);
    vecs[nvec++] = mk(1, 1, 2'd2, 0, 32'h004, 64'hCAFE_BABE,         64'h0,                 0, 8'hF0, 64'hCAFE_BABE_CAFE_BABE, 32'h000, 64'h0);

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.a_outs", {a_lsu_stall, a_resp_valid, a_exc_mis, a_exc_bus, a_exc_to, a_dmem_en}, 0);
    check("rst.a_vals", {a_dmem_rw, a_dmem_addr, a_resp_rdata}, 0);
    check("rst.b_outs", {b_lsu_stall, b_resp_valid, b_exc_mis, b_exc_bus, b_exc_to, b_dmem_en}, 0);
    check("rst.b_rw", b_dmem_rw, 0);
    rst = 0;

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // Timeout: ready never comes, enable stays up for TIMEOUT_CYCLES cycles.
    start_a(32'h500, 2'd2);
    en_cnt = a_dmem_en ? 1 : 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (a_exc_to) seen = 1;
      else if (a_dmem_en) en_cnt++;
    end
    check("to.seen", seen, 1);
    check("to.en_cycles", en_cnt, 4);
    check("to.others", {a_resp_valid, a_exc_bus, a_exc_mis, a_dmem_en}, 0);
    @(posedge clk); #1;
    check("to.clr", a_exc_to, 0);

    // Ready in the same cycle the counter expires: ready wins.
    start_a(32'h504, 2'd2);
    repeat (3) @(posedge clk);
    #1;
    a_dmem_ready = 1; a_dmem_in = 32'h1122_3344;
    @(posedge clk); #1;
    a_dmem_ready = 0;
    check("rdy_vs_to.resp", a_resp_valid, 1);
    check("rdy_vs_to.to", a_exc_to, 0);
    check("rdy_vs_to.rdata", a_resp_rdata, 32'h1122_3344);

    // Error and ready together: error wins.
    start_a(32'h600, 2'd2);
    a_dmem_ready = 1; a_dmem_error = 1; a_dmem_in = 32'h5555_5555;
    @(posedge clk); #1;
    a_dmem_ready = 0; a_dmem_error = 0;
    check("err.bus", a_exc_bus, 1);
    check("err.resp", a_resp_valid, 0);
    check("err.addr", a_exc_addr, 32'h600);
    check("err.en", a_dmem_en, 0);
    @(posedge clk); #1;
    check("err.clr", a_exc_bus, 0);

    // Reset in the second WAIT cycle, late ready must be ignored.
    start_a(32'h700, 2'd2);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    a_dmem_ready = 1; a_dmem_in = 32'h9999_9999;
    #1;
    check("mid_rst.ctl", {a_lsu_stall, a_resp_valid, a_exc_mis, a_exc_bus, a_exc_to, a_dmem_en}, 0);
    check("mid_rst.vals", {a_dmem_rw, a_dmem_addr, a_resp_rdata, a_exc_addr}, 0);
    @(posedge clk); #1;
    a_dmem_ready = 0;
    check("mid_rst.no_resp", {a_resp_valid, a_dmem_en}, 0);
    run_vec(vecs[0], 99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/elbeth_lsu.md
Name: elbeth_lsu

Overview:
Parametrised load/store unit between the EXS stage and the data memory port. It replaces the core's direct wiring of ALU result, rs2 data and byte lanes to dmem with a handshaked FSM. The FSM handles:
- byte-lane enables and write-data replication;
- alignment checks;
- load extraction with sign or zero extension;
- bus-error and timeout exceptions.

It asserts a stall to the control unit while an access is outstanding.

Parameters:
XLEN, 32, data width; 32 or 64. Byte lanes NB = XLEN/8.
ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 16, WAIT cycles before a timeout exception; must be at least 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  access request from EXS
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN = 64)
req_signed  in  1  sign-extend loads
req_addr  in  ADDR_WIDTH  effective address
req_wdata  in  XLEN  store data, right-aligned
lsu_stall  out  1  holds the pipeline
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data
exc_misaligned  out  1  one-cycle pulse
exc_bus_error  out  1  one-cycle pulse
exc_timeout  out  1  one-cycle pulse
exc_addr  out  ADDR_WIDTH  faulting address
dmem_addr  out  ADDR_WIDTH  address, aligned down to NB
dmem_en  out  1  access enable
dmem_rw  out  NB  byte write enables; all zero = read
dmem_out_data  out  XLEN  lane-replicated store data
dmem_in_data  in  XLEN  read data
dmem_ready  in  1  access complete
dmem_error  in  1  access failed

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- States: IDLE, WAIT, RESP.
- Alignment rule: an access is misaligned when req_addr is not a multiple of 2^req_size. size = 3 with XLEN = 32 is also misaligned.
- IDLE, req_valid with a misaligned access:
  - no memory access is made (dmem_en stays 0);
  - next edge: exc_misaligned = 1 and exc_addr = req_addr, then state RESP.
- IDLE, req_valid with an aligned access:
  - next edge: register dmem_addr (low log2(NB) bits cleared), dmem_en = 1, dmem_rw and dmem_out_data;
  - latch the offset, size and signed flag; clear the counter; state WAIT.
- Byte enables: dmem_rw = ((1 << 2^size) - 1) << offset for stores; all zero for loads.
- Store data: req_wdata's low 2^size bytes replicated across every lane.
- WAIT:
  - dmem outputs are held stable;
  - the counter increments each cycle.
- WAIT exits, in priority order:
  1. dmem_error = 1: exc_bus_error = 1, exc_addr = the request address. Error wins over a simultaneous dmem_ready.
  2. dmem_ready = 1: resp_valid = 1. For loads, resp_rdata = dmem_in_data >> (8*offset), truncated to 2^size bytes, then sign- or zero-extended to XLEN. Ready wins over a simultaneous timeout expiry.
  3. Counter reaches TIMEOUT_CYCLES - 1 with neither error nor ready: exc_timeout = 1.
- On every WAIT exit: dmem_en = 0, dmem_rw = 0, state RESP.
- RESP:
  - the response or exception pulse is visible for exactly one cycle;
  - the pulses clear on the next edge, state IDLE;
  - a new req_valid is accepted only from IDLE.
- Stall:
  - lsu_stall = (state == WAIT) | (state == IDLE & req_valid), combinational;
  - lsu_stall = 0 in RESP, so the pipeline advances on the response cycle.
- Latency: a zero-wait-state memory (ready in the first WAIT cycle) gives resp_valid 2 cycles after request acceptance.
- Store response: resp_rdata = 0.
- resp_rdata hold: resp_rdata holds its value until the next response.
- Reset mid-operation: rst in WAIT or RESP returns to IDLE at that edge. dmem_en drops and no pulse is emitted. A memory response arriving later is ignored while in IDLE.
- Pulse exclusivity: resp_valid and the three exc_* pulses are mutually exclusive.

Decomposition:
- Shared package elbeth_lsu_pkg:
  - size encodings SIZE_B/H/W/D;
  - state encodings LSU_IDLE/WAIT/RESP;
  - function for the byte-enable mask.
- Sub-module elbeth_load_align: combinational shift, truncate and extend of the load data. It generalises elbeth_zero_signed_extend to XLEN and offset.
- FSM, counter and store replication stay in elbeth_lsu.

Test Plan:
- XLEN = 32, load byte, signed, addr 0x103, memory returns 0x80FF_1234 with ready in the first WAIT cycle -> resp_valid 2 cycles after acceptance, resp_rdata 0xFFFF_FF80, dmem_addr 0x100, dmem_rw 4'b0000.
- Store half, addr 0x202, wdata 0x0000_ABCD -> dmem_rw 4'b1100, dmem_out_data 0xABCD_ABCD, lsu_stall high until ready, resp_valid pulse.
- Load word, addr 0x001 -> exc_misaligned 1 cycle after the request, exc_addr 0x001, dmem_en never high.
- TIMEOUT_CYCLES = 4, ready never asserted -> dmem_en high for exactly 4 cycles, then exc_timeout pulse. Separate case: ready and error asserted in the same cycle -> exc_bus_error only.
- rst asserted in the second WAIT cycle, ready arriving one cycle later -> all outputs 0, no resp_valid, next request serviced normally.
- XLEN = 64, load double, unsigned, addr 0x8, data 0xDEAD_BEEF_0123_4567 -> dmem_rw 8'h00 on the read, resp_rdata equal to the data. Second case: size = 3 with XLEN = 32 -> exc_misaligned.
